// File: rtl/flag_cond_pkg.sv
// Shared definitions for the adder flag consumer: condition codes, FSM states
// and bit positions inside the held status vector.
package flag_cond_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    BUSY  = 2'd2
  } state_e;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_PE = 4'd8;
  localparam logic [3:0] COND_PO = 4'd9;
  localparam logic [3:0] COND_LT = 4'd10;
  localparam logic [3:0] COND_GE = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  // status = {overflow, zero, parity, sign, carry}
  localparam int ST_C = 0;
  localparam int ST_S = 1;
  localparam int ST_P = 2;
  localparam int ST_Z = 3;
  localparam int ST_V = 4;

endpackage

// File: rtl/flag_cond_unit_cond_eval.sv
// Combinational condition-code evaluator over the held status flags.
module cond_eval
  import flag_cond_pkg::*;
(
  input  logic [4:0] status_i,
  input  logic [3:0] cond_code_i,
  output logic       cond_true_o
);

  logic c, s, p, z, v, lt;

  assign c  = status_i[ST_C];
  assign s  = status_i[ST_S];
  assign p  = status_i[ST_P];
  assign z  = status_i[ST_Z];
  assign v  = status_i[ST_V];
  assign lt = s ^ v;

  always_comb begin
    cond_true_o = 1'b0;
    case (cond_code_i)
      COND_EQ: cond_true_o = z;
      COND_NE: cond_true_o = !z;
      COND_CS: cond_true_o = c;
      COND_CC: cond_true_o = !c;
      COND_MI: cond_true_o = s;
      COND_PL: cond_true_o = !s;
      COND_VS: cond_true_o = v;
      COND_VC: cond_true_o = !v;
      COND_PE: cond_true_o = p;
      COND_PO: cond_true_o = !p;
      COND_LT: cond_true_o = lt;
      COND_GE: cond_true_o = !lt;
      COND_GT: cond_true_o = !z && !lt;
      COND_LE: cond_true_o = z || lt;
      COND_AL: cond_true_o = 1'b1;
      COND_NV: cond_true_o = 1'b0;
      default: cond_true_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_cond_unit.sv
// Captures adder results and flags, cross-checks derivable flags, answers
// condition-code queries and keeps sticky/counted overflow statistics.
module flag_cond_unit
  import flag_cond_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [WIDTH-1:0] res_z,
  input  logic             res_carry,
  input  logic             res_sign,
  input  logic             res_parity,
  input  logic             res_zero,
  input  logic             res_overflow,
  input  logic             cond_req,
  input  logic [3:0]       cond_code,
  output logic             cond_ack,
  output logic             cond_true,
  output logic             cond_err,
  output logic             flags_valid,
  output logic [4:0]       status,
  output logic [WIDTH-1:0] z_hold,
  output logic             flag_err,
  output logic             sticky_ovf,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clr_sticky
);

  state_e           state_q, state_d;
  logic             flags_valid_q, flags_valid_d;
  logic [4:0]       status_q, status_d;
  logic [WIDTH-1:0] z_hold_q, z_hold_d;
  logic             flag_err_q, flag_err_d;
  logic             sticky_ovf_q, sticky_ovf_d;
  logic [CNT_W-1:0] ovf_count_q, ovf_count_d;
  logic             cond_ack_q, cond_ack_d;
  logic             cond_true_q, cond_true_d;
  logic             cond_err_q, cond_err_d;

  logic capture, query, eval_true, inconsistent;

  assign res_ready = (state_q != BUSY);
  assign capture   = res_valid && res_ready;
  assign query     = cond_req && (state_q != BUSY);

  // Queries always see the flags held before this edge, even on a same-cycle capture.
  cond_eval u_cond_eval (
    .status_i    (status_q),
    .cond_code_i (cond_code),
    .cond_true_o (eval_true)
  );

  assign inconsistent = (res_zero != (res_z == '0))
                      | (res_sign != res_z[WIDTH-1])
                      | (res_parity != (^res_z));

  always_comb begin
    state_d       = state_q;
    flags_valid_d = flags_valid_q;
    status_d      = status_q;
    z_hold_d      = z_hold_q;
    flag_err_d    = flag_err_q;
    sticky_ovf_d  = sticky_ovf_q;
    ovf_count_d   = ovf_count_q;
    cond_ack_d    = query;
    cond_true_d   = query && flags_valid_q && eval_true;
    cond_err_d    = query && !flags_valid_q;

    if (query)
      state_d = BUSY;
    else if (state_q == BUSY)
      state_d = flags_valid_q ? HOLD : EMPTY;
    else if (capture)
      state_d = HOLD;

    if (capture) begin
      flags_valid_d = 1'b1;
      z_hold_d      = res_z;
      status_d      = {res_overflow, res_zero, res_parity, res_sign, res_carry};
    end

    // Clearing wins over any statistic update in the same cycle.
    if (clr_sticky) begin
      flag_err_d   = 1'b0;
      sticky_ovf_d = 1'b0;
      ovf_count_d  = '0;
    end else if (capture) begin
      if (inconsistent)
        flag_err_d = 1'b1;
      if (res_overflow) begin
        sticky_ovf_d = 1'b1;
        if (ovf_count_q != '1)
          ovf_count_d = ovf_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= EMPTY;
      flags_valid_q <= 1'b0;
      status_q      <= '0;
      z_hold_q      <= '0;
      flag_err_q    <= 1'b0;
      sticky_ovf_q  <= 1'b0;
      ovf_count_q   <= '0;
      cond_ack_q    <= 1'b0;
      cond_true_q   <= 1'b0;
      cond_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      flags_valid_q <= flags_valid_d;
      status_q      <= status_d;
      z_hold_q      <= z_hold_d;
      flag_err_q    <= flag_err_d;
      sticky_ovf_q  <= sticky_ovf_d;
      ovf_count_q   <= ovf_count_d;
      cond_ack_q    <= cond_ack_d;
      cond_true_q   <= cond_true_d;
      cond_err_q    <= cond_err_d;
    end
  end

  assign flags_valid = flags_valid_q;
  assign status      = status_q;
  assign z_hold      = z_hold_q;
  assign flag_err    = flag_err_q;
  assign sticky_ovf  = sticky_ovf_q;
  assign ovf_count   = ovf_count_q;
  assign cond_ack    = cond_ack_q;
  assign cond_true   = cond_true_q;
  assign cond_err    = cond_err_q;

endmodule

// File: tb/tb_flag_cond_unit.sv
// Directed bench for flag_cond_unit: inputs change and outputs are sampled on
// the falling clock edge, expected values are hand-computed constants.
module tb_flag_cond_unit;

  logic        clk;
  logic        rstN;
  logic        resValid;
  logic        resReady;
  logic [15:0] resZ;
  logic        resCarry, resSign, resParity, resZero, resOverflow;
  logic        condReq;
  logic [3:0]  condCode;
  logic        condAck, condTrue, condErr;
  logic        flagsValid;
  logic [4:0]  status;
  logic [15:0] zHold;
  logic        flagErr, stickyOvf;
  logic [7:0]  ovfCount;
  logic        clrSticky;

  int checkCount = 0;
  int passCount  = 0;

  flag_cond_unit #(.WIDTH(16), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rstN),
    .res_valid    (resValid),
    .res_ready    (resReady),
    .res_z        (resZ),
    .res_carry    (resCarry),
    .res_sign     (resSign),
    .res_parity   (resParity),
    .res_zero     (resZero),
    .res_overflow (resOverflow),
    .cond_req     (condReq),
    .cond_code    (condCode),
    .cond_ack     (condAck),
    .cond_true    (condTrue),
    .cond_err     (condErr),
    .flags_valid  (flagsValid),
    .status       (status),
    .z_hold       (zHold),
    .flag_err     (flagErr),
    .sticky_ovf   (stickyOvf),
    .ovf_count    (ovfCount),
    .clr_sticky   (clrSticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Presents one result for a single cycle; flags are {V, Z, P, S, C}.
  task automatic applyStimulus(input logic [15:0] z, input logic [4:0] f);
    @(negedge clk);
    resValid = 1'b1;
    resZ = z;
    {resOverflow, resZero, resParity, resSign, resCarry} = f;
    @(negedge clk);
    resValid = 1'b0;
  endtask

  // One query; checks the response strobe and that it lasts a single cycle.
  task automatic applyQuery(input string tag, input logic [3:0] code,
                            input logic expTrue, input logic expErr);
    @(negedge clk);
    condReq = 1'b1;
    condCode = code;
    @(negedge clk);
    condReq = 1'b0;
    checkOutput({tag, "_ack"}, 32'(condAck), 32'd1);
    checkOutput({tag, "_true"}, 32'(condTrue), 32'(expTrue));
    checkOutput({tag, "_err"}, 32'(condErr), 32'(expErr));
    checkOutput({tag, "_busy_ready"}, 32'(resReady), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_ack_drop"}, 32'(condAck), 32'd0);
  endtask

  initial begin
    rstN = 1'b0;
    resValid = 1'b0;
    resZ = '0;
    {resOverflow, resZero, resParity, resSign, resCarry} = 5'b0;
    condReq = 1'b0;
    condCode = '0;
    clrSticky = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;

    checkOutput("rst_ready", 32'(resReady), 32'd1);
    checkOutput("rst_ack", 32'(condAck), 32'd0);
    checkOutput("rst_fv", 32'(flagsValid), 32'd0);
    checkOutput("rst_status", 32'(status), 32'd0);
    checkOutput("rst_zhold", 32'(zHold), 32'd0);
    checkOutput("rst_cnt", 32'(ovfCount), 32'd0);

    applyQuery("q_empty", 4'd0, 1'b0, 1'b1);

    applyStimulus(16'h0003, 5'b00000);
    checkOutput("c1_fv", 32'(flagsValid), 32'd1);
    checkOutput("c1_zhold", 32'(zHold), 32'h0003);
    checkOutput("c1_status", 32'(status), 32'h00);
    checkOutput("c1_ferr", 32'(flagErr), 32'd0);
    checkOutput("c1_cnt", 32'(ovfCount), 32'd0);
    applyQuery("c1_ne", 4'd1, 1'b1, 1'b0);
    applyQuery("c1_eq", 4'd0, 1'b0, 1'b0);

    applyStimulus(16'h8000, 5'b10110);
    checkOutput("c2_status", 32'(status), 32'h16);
    checkOutput("c2_sticky", 32'(stickyOvf), 32'd1);
    checkOutput("c2_cnt", 32'(ovfCount), 32'd1);
    checkOutput("c2_ferr", 32'(flagErr), 32'd0);
    applyQuery("c2_lt", 4'd10, 1'b0, 1'b0);
    applyQuery("c2_ge", 4'd11, 1'b1, 1'b0);
    applyQuery("c2_mi", 4'd4, 1'b1, 1'b0);

    applyStimulus(16'h0000, 5'b01001);
    checkOutput("c3_status", 32'(status), 32'h09);
    checkOutput("c3_cnt", 32'(ovfCount), 32'd1);
    applyQuery("c3_eq", 4'd0, 1'b1, 1'b0);
    applyQuery("c3_cs", 4'd2, 1'b1, 1'b0);
    applyQuery("c3_gt", 4'd12, 1'b0, 1'b0);
    applyQuery("c3_le", 4'd13, 1'b1, 1'b0);

    applyStimulus(16'h0000, 5'b00000);
    checkOutput("c4_ferr", 32'(flagErr), 32'd1);
    @(negedge clk);
    clrSticky = 1'b1;
    @(negedge clk);
    clrSticky = 1'b0;
    checkOutput("clr_ferr", 32'(flagErr), 32'd0);
    checkOutput("clr_sticky", 32'(stickyOvf), 32'd0);
    checkOutput("clr_cnt", 32'(ovfCount), 32'd0);
    checkOutput("clr_fv", 32'(flagsValid), 32'd1);
    checkOutput("clr_zhold", 32'(zHold), 32'h0000);

    // Same-cycle capture and query: the answer comes from the older flags.
    applyStimulus(16'h0003, 5'b00000);
    @(negedge clk);
    resValid = 1'b1;
    resZ = 16'h0000;
    {resOverflow, resZero, resParity, resSign, resCarry} = 5'b01000;
    condReq = 1'b1;
    condCode = 4'd0;
    @(negedge clk);
    resValid = 1'b0;
    condReq = 1'b0;
    checkOutput("same_ack", 32'(condAck), 32'd1);
    checkOutput("same_true", 32'(condTrue), 32'd0);
    checkOutput("same_err", 32'(condErr), 32'd0);
    checkOutput("same_status", 32'(status), 32'h08);
    @(negedge clk);
    checkOutput("same_ack_drop", 32'(condAck), 32'd0);
    applyQuery("same_eq2", 4'd0, 1'b1, 1'b0);

    // An overflow capture coinciding with clr_sticky is dropped.
    @(negedge clk);
    resValid = 1'b1;
    resZ = 16'h8000;
    {resOverflow, resZero, resParity, resSign, resCarry} = 5'b10110;
    clrSticky = 1'b1;
    @(negedge clk);
    resValid = 1'b0;
    clrSticky = 1'b0;
    checkOutput("clrpri_cnt", 32'(ovfCount), 32'd0);
    checkOutput("clrpri_sticky", 32'(stickyOvf), 32'd0);
    checkOutput("clrpri_status", 32'(status), 32'h16);

    @(negedge clk);
    resValid = 1'b1;
    repeat (255) @(negedge clk);
    checkOutput("sat_255", 32'(ovfCount), 32'd255);
    @(negedge clk);
    resValid = 1'b0;
    checkOutput("sat_hold", 32'(ovfCount), 32'd255);
    checkOutput("sat_sticky", 32'(stickyOvf), 32'd1);

    // Reset landing between request and response suppresses the ack.
    @(negedge clk);
    condReq = 1'b1;
    condCode = 4'd14;
    #2 rstN = 1'b0;
    #1 condReq = 1'b0;
    @(negedge clk);
    checkOutput("rstq_ack", 32'(condAck), 32'd0);
    checkOutput("rstq_fv", 32'(flagsValid), 32'd0);
    checkOutput("rstq_cnt", 32'(ovfCount), 32'd0);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("rstq_ready", 32'(resReady), 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
